mem_access_unit: RTL and testbench

Memory-stage load/store unit between the E/M pipeline register and the W pipeline register. It turns the M-stage access request into a single-outstanding data-bus transaction with a req/ack handshake, and holds the pipeline while the access is in flight. It aligns and extends load data into `m_memout` and forwards the ALU result as `m_data`. All outputs feed the W-stage register inputs of the same names.

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one outstanding req/ack data-bus access, pipeline hold, load align/extend.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_rmem,
    input  logic              m_wmem,
    input  logic [1:0]        m_size,
    input  logic              m_sext,
    input  logic [31:0]       m_alu,
    input  logic [31:0]       m_b,
    input  logic              m_wreg_i,
    output logic              m_wreg,
    output logic [31:0]       m_data,
    output logic [31:0]       m_memout,
    output logic              m_mem_stall,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              m_misalign,
`endif
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_acc;
    logic              w_legal;
    logic              w_issue;
    logic              w_stall;
    logic [1:0]        w_off;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata_q;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_sext;
    logic              r_load;

    // Lane actually used: sub-size address bits are dropped so half/word always hit a natural lane.
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lane_offset = lo;
            2'b01:   lane_offset = {lo[1], 1'b0};
            default: lane_offset = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_enables = 4'b0001 << off;
            2'b01:   byte_enables = 4'b0011 << off;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] b);
        case (size)
            2'b00:   store_data = {4{b[7:0]}};
            2'b01:   store_data = {2{b[15:0]}};
            default: store_data = b;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [1:0] size, input logic sext,
                                               input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_align = sext ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
            2'b01:   load_align = sext ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            default: load_align = rdata;
        endcase
    endfunction

    assign w_acc = m_rmem | m_wmem;
    assign w_off = lane_offset(m_size, m_alu[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;

    always_comb begin
        case (m_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = m_alu[0];
            default: w_misaligned = |m_alu[1:0];
        endcase
    end

    assign w_legal    = ~w_misaligned;
    assign m_misalign = (r_state == S_IDLE) & w_acc & w_misaligned;
    assign m_wreg     = m_wreg_i & ~m_misalign;
`else
    assign w_legal = 1'b1;
    assign m_wreg  = m_wreg_i;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc && w_legal) begin
                    w_issue = 1'b1;
                    w_stall = 1'b1;
                    w_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (dmem_ack) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus request and access context; a load wins when both rmem and wmem are set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= 4'b0000;
            r_wdata   <= 32'd0;
            r_rdata_q <= 32'd0;
            r_off     <= 2'b00;
            r_size    <= 2'b00;
            r_sext    <= 1'b0;
            r_load    <= 1'b0;
        end else if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= m_wmem & ~m_rmem;
            r_addr  <= {m_alu[ADDR_W-1:2], 2'b00};
            r_be    <= byte_enables(m_size, w_off);
            r_wdata <= store_data(m_size, m_b);
            r_off   <= w_off;
            r_size  <= m_size;
            r_sext  <= m_sext;
            r_load  <= m_rmem;
        end else if (r_state == S_BUSY && dmem_ack) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_rdata_q <= dmem_rdata;
        end
    end

    assign dmem_req    = r_req;
    assign dmem_we     = r_we;
    assign dmem_addr   = r_addr;
    assign dmem_be     = r_be;
    assign dmem_wdata  = r_wdata;
    assign m_mem_stall = w_stall;
    assign m_data      = m_alu;
    assign m_memout    = (r_state == S_DONE && r_load) ?
                         load_align(r_size, r_sext, r_off, r_rdata_q) : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboard of expected bus/load results checked with immediate assertions.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m_rmem, m_wmem, m_sext, m_wreg_i;
    logic [1:0]  m_size;
    logic [31:0] m_alu, m_b;
    logic        m_wreg, m_mem_stall;
    logic [31:0] m_data, m_memout;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        m_misalign;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] memout;
        logic        wreg;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m_rmem      (m_rmem),
        .m_wmem      (m_wmem),
        .m_size      (m_size),
        .m_sext      (m_sext),
        .m_alu       (m_alu),
        .m_b         (m_b),
        .m_wreg_i    (m_wreg_i),
        .m_wreg      (m_wreg),
        .m_data      (m_data),
        .m_memout    (m_memout),
        .m_mem_stall (m_mem_stall),
`ifdef MEM_MISALIGN_TRAP_EN
        .m_misalign  (m_misalign),
`endif
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m_rmem   = 1'b0;
        m_wmem   = 1'b0;
        m_size   = 2'b00;
        m_sext   = 1'b0;
        m_alu    = 32'h0;
        m_b      = 32'h0;
        m_wreg_i = 1'b0;
    endtask

    // One instruction through M: IDLE cycle, n_busy BUSY cycles (ack on the last), then DONE.
    task automatic access(input string tag, input logic rmem, input logic wmem,
                          input logic [1:0] size, input logic sext,
                          input logic [31:0] alu, input logic [31:0] b, input logic wreg_i,
                          input int n_busy, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic e_we,
                          input logic [31:0] e_memout);
        exp_t e;
        int   stall_cnt;
        e.addr = e_addr; e.be = e_be; e.wdata = e_wdata; e.we = e_we;
        e.memout = e_memout; e.wreg = wreg_i;
        stall_cnt = 0;
        @(posedge clk); #1;
        m_rmem = rmem; m_wmem = wmem; m_size = size; m_sext = sext;
        m_alu = alu; m_b = b; m_wreg_i = wreg_i;
        sb.push_back(e);
        #1;
        chk({tag, " idle req"}, dmem_req, 1'b0);
        chk({tag, " m_data"}, m_data, alu);
        if (m_mem_stall) stall_cnt++;
        for (int i = 1; i <= n_busy; i++) begin
            @(posedge clk); #1;
            dmem_ack   = (i == n_busy);
            dmem_rdata = (i == n_busy) ? rdata : $urandom;
            #1;
            chk($sformatf("%s busy%0d req", tag, i), dmem_req, 1'b1);
            chk($sformatf("%s busy%0d addr", tag, i), dmem_addr, sb[0].addr);
            chk($sformatf("%s busy%0d be", tag, i), dmem_be, sb[0].be);
            chk($sformatf("%s busy%0d wdata", tag, i), dmem_wdata, sb[0].wdata);
            chk($sformatf("%s busy%0d we", tag, i), dmem_we, sb[0].we);
            if (m_mem_stall) stall_cnt++;
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        #1;
        e = sb.pop_front();
        chk({tag, " done stall"}, m_mem_stall, 1'b0);
        chk({tag, " done req"}, dmem_req, 1'b0);
        chk({tag, " stall cycles"}, stall_cnt, n_busy + 1);
        chk({tag, " memout"}, m_memout, e.memout);
        chk({tag, " wreg"}, m_wreg, e.wreg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetn     = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst req", dmem_req, 1'b0);
        chk("rst we", dmem_we, 1'b0);
        chk("rst addr", dmem_addr, 32'h0);
        chk("rst be", dmem_be, 4'b0000);
        chk("rst wdata", dmem_wdata, 32'h0);
        chk("rst stall", m_mem_stall, 1'b0);
        chk("rst memout", m_memout, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rst misalign", m_misalign, 1'b0);
`endif
        @(posedge clk); #1;
        resetn = 1'b1;

        // Non-memory instruction passes through without stalling; stray ack in IDLE is ignored.
        @(posedge clk); #1;
        m_alu = 32'hCAFE_0001; m_wreg_i = 1'b1; dmem_ack = 1'b1;
        #1;
        chk("alu stall", m_mem_stall, 1'b0);
        chk("alu m_data", m_data, 32'hCAFE_0001);
        chk("alu wreg", m_wreg, 1'b1);
        @(posedge clk); #1;
        dmem_ack = 1'b0; idle_inputs();
        #1;
        chk("stray ack req", dmem_req, 1'b0);
        chk("stray ack stall", m_mem_stall, 1'b0);

        access("ldw", 1, 0, 2'b10, 0, 32'h0000_1004, 32'h0, 1, 1, 32'hDEAD_BEEF,
               32'h0000_1004, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF);
        access("ldb sx", 1, 0, 2'b00, 1, 32'h0000_2002, 32'h0, 1, 1, 32'h0080_0000,
               32'h0000_2000, 4'b0100, 32'h0, 0, 32'hFFFF_FF80);
        access("ldb zx", 1, 0, 2'b00, 0, 32'h0000_2002, 32'h0, 1, 1, 32'h0080_0000,
               32'h0000_2000, 4'b0100, 32'h0, 0, 32'h0000_0080);
        access("ldh sx", 1, 0, 2'b01, 1, 32'h0000_2402, 32'h0, 1, 2, 32'h8001_1234,
               32'h0000_2400, 4'b1100, 32'h0, 0, 32'hFFFF_8001);
        access("sth", 0, 1, 2'b01, 0, 32'h0000_3002, 32'h1234_ABCD, 0, 4, 32'h5555_5555,
               32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 1, 32'h0);
        access("stb", 0, 1, 2'b00, 0, 32'h0000_3003, 32'h0000_00A5, 0, 1, 32'h0,
               32'h0000_3000, 4'b1000, 32'hA5A5_A5A5, 1, 32'h0);
        access("rw both", 1, 1, 2'b11, 0, 32'h0000_3100, 32'h7777_7777, 1, 1, 32'h0BAD_F00D,
               32'h0000_3100, 4'b1111, 32'h7777_7777, 0, 32'h0BAD_F00D);
        access("b2b 1", 1, 0, 2'b10, 0, 32'h0000_4000, 32'h0, 1, 1, 32'h1111_2222,
               32'h0000_4000, 4'b1111, 32'h0, 0, 32'h1111_2222);
        access("b2b 2", 1, 0, 2'b10, 0, 32'h0000_4004, 32'h0, 1, 1, 32'h3333_4444,
               32'h0000_4004, 4'b1111, 32'h0, 0, 32'h3333_4444);

        // Reset pulse in the middle of BUSY abandons the transaction.
        @(posedge clk); #1;
        m_rmem = 1'b1; m_size = 2'b10; m_alu = 32'h0000_5000; m_wreg_i = 1'b1;
        @(posedge clk); #1;
        #1;
        chk("rst mid busy req before", dmem_req, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst mid busy req", dmem_req, 1'b0);
        chk("rst mid busy addr", dmem_addr, 32'h0);
        chk("rst mid busy be", dmem_be, 4'b0000);
        idle_inputs();
        #1;
        chk("rst mid busy stall", m_mem_stall, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #2;
        chk("post rst stall", m_mem_stall, 1'b0);
        chk("post rst req", dmem_req, 1'b0);
        chk("post rst memout", m_memout, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        m_rmem = 1'b1; m_size = 2'b10; m_alu = 32'h0000_6002; m_wreg_i = 1'b1;
        #1;
        chk("mis misalign", m_misalign, 1'b1);
        chk("mis stall", m_mem_stall, 1'b0);
        chk("mis wreg", m_wreg, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("mis no req", dmem_req, 1'b0);
        chk("mis pulse end", m_misalign, 1'b0);
`else
        access("ldw mis", 1, 0, 2'b10, 0, 32'h0000_6002, 32'h0, 1, 1, 32'h1122_3344,
               32'h0000_6000, 4'b1111, 32'h0, 0, 32'h1122_3344);
        access("ldh odd", 1, 0, 2'b01, 0, 32'h0000_6003, 32'h0, 1, 1, 32'hBEEF_0000,
               32'h0000_6000, 4'b1100, 32'h0, 0, 32'h0000_BEEF);
`endif

        @(posedge clk); #1;
        idle_inputs();
        chk("scoreboard empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
